led_display_scan_ctrl: RTL and testbench

LED_DISPLAY_SCAN_CTRL -- requirements
Module: led_display_scan_ctrl

---
 rtl/led_display_package.sv | 25 ++
 rtl/led_display_oe_timer.sv | 51 +++++
 rtl/led_display_scan_ctrl.sv | 167 ++++++++++++++++
 tb/tb_led_display_scan_ctrl.sv | 353 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/led_display_package.sv
// Shared types and constants for the LED panel scan controller.
// Holds the scan state enum, row address width and pixel column type.
package led_display_package;

  localparam int ROW_AW     = 4;
  localparam int SHIFT_HOLD = 3;

  typedef logic [2:0] pxl_col_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_SHIFT,
    ST_BLANK,
    ST_LATCH,
    ST_DISPLAY
  } scan_state_t;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/led_display_oe_timer.sv
// DISPLAY period counter producing the on-time window and end-of-row flag.
// LED_SCAN_BRIGHTNESS_EN scales the on window by brightness_in/256.
module led_display_oe_timer
  import led_display_package::*;
#(
  parameter int ON_TIME_CYCLES = 1000
) (
  input  logic       clk_in,
  input  logic       reset_in,
  input  logic       start_in,
`ifdef LED_SCAN_BRIGHTNESS_EN
  input  logic [7:0] brightness_in,
`endif
  output logic       done_out,
  output logic       oe_n_out
);

  localparam int CW = (ON_TIME_CYCLES > 1) ? $clog2(ON_TIME_CYCLES + 1) : 1;

  logic          r_active;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] r_on;
  logic [CW-1:0] w_on;

`ifdef LED_SCAN_BRIGHTNESS_EN
  logic [39:0] w_prod;
  assign w_prod = 40'(ON_TIME_CYCLES) * 40'(brightness_in);
  assign w_on   = CW'(w_prod >> 8);
`else
  assign w_on = CW'(ON_TIME_CYCLES);
`endif

  assign done_out = r_active && (r_cnt == CW'(ON_TIME_CYCLES - 1));
  assign oe_n_out = !(r_active && (r_cnt < r_on));

  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      r_active <= 1'b0;
      r_cnt    <= '0;
      r_on     <= '0;
    end else if (start_in) begin
      r_active <= 1'b1;
      r_cnt    <= '0;
      r_on     <= w_on;
    end else if (r_active) begin
      if (done_out) r_active <= 1'b0;
      else          r_cnt    <= r_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/led_display_scan_ctrl.sv
// HUB75-style row-pair scan sequencer: fetch, shift, blank, latch, display.
// Optional LED_SCAN_BRIGHTNESS_EN adds brightness_in PWM of the on window.
module led_display_scan_ctrl
  import led_display_package::*;
#(
  parameter int NUM_COLS       = 64,
  parameter int NUM_ROWS       = 32,
  parameter int ON_TIME_CYCLES = 1000,
  parameter int BLANK_CYCLES   = 4,
  parameter int LATCH_CYCLES   = 2
) (
  input  logic                    clk_in,
  input  logic                    reset_in,
  input  logic                    enable_in,
`ifdef LED_SCAN_BRIGHTNESS_EN
  input  logic [7:0]              brightness_in,
`endif
  output logic                    row_req_out,
  output logic [ROW_AW-1:0]       row_addr_out,
  input  logic                    row_valid_in,
  input  pxl_col_t [NUM_COLS-1:0] col_top_in,
  input  pxl_col_t [NUM_COLS-1:0] col_bot_in,
  output logic                    phy_enable_out,
  input  logic                    phy_ready_in,
  output pxl_col_t [NUM_COLS-1:0] phy_col_top_out,
  output pxl_col_t [NUM_COLS-1:0] phy_col_bot_out,
  output logic [ROW_AW-1:0]       addr_out,
  output logic                    le_out,
  output logic                    oe_n_out,
  output logic                    frame_done_out,
  output logic                    busy_out
);

  localparam int LAST_ROW = NUM_ROWS / 2 - 1;
  localparam int CNT_MAX  = max3(BLANK_CYCLES, LATCH_CYCLES, SHIFT_HOLD);
  localparam int CW       = $clog2(CNT_MAX + 1);

  scan_state_t             r_state;
  scan_state_t             w_state_nxt;
  logic [ROW_AW-1:0]       r_row;
  logic [ROW_AW-1:0]       w_row_nxt;
  logic [CW-1:0]           r_cnt;
  logic [ROW_AW-1:0]       r_addr;
  pxl_col_t [NUM_COLS-1:0] r_top;
  pxl_col_t [NUM_COLS-1:0] r_bot;
  logic                    r_frame_done;

  logic w_cnt_clr;
  logic w_capture;
  logic w_addr_load;
  logic w_disp_start;
  logic w_disp_done;
  logic w_fd_nxt;
  logic w_oe_n;

  led_display_oe_timer #(
    .ON_TIME_CYCLES(ON_TIME_CYCLES)
  ) u_oe_timer (
    .clk_in       (clk_in),
    .reset_in     (reset_in),
    .start_in     (w_disp_start),
`ifdef LED_SCAN_BRIGHTNESS_EN
    .brightness_in(brightness_in),
`endif
    .done_out     (w_disp_done),
    .oe_n_out     (w_oe_n)
  );

  always_comb begin
    w_state_nxt  = r_state;
    w_row_nxt    = r_row;
    w_cnt_clr    = 1'b0;
    w_capture    = 1'b0;
    w_addr_load  = 1'b0;
    w_disp_start = 1'b0;
    w_fd_nxt     = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (enable_in) begin
          w_state_nxt = ST_FETCH;
          w_row_nxt   = '0;
          w_cnt_clr   = 1'b1;
        end
      end
      ST_FETCH: begin
        if (row_valid_in) begin
          w_capture   = 1'b1;
          w_state_nxt = ST_SHIFT;
          w_cnt_clr   = 1'b1;
        end
      end
      ST_SHIFT: begin
        // Ready is only trusted once the PHY has seen the enable.
        if (r_cnt >= CW'(SHIFT_HOLD) && phy_ready_in) begin
          w_state_nxt = ST_BLANK;
          w_cnt_clr   = 1'b1;
        end
      end
      ST_BLANK: begin
        if (r_cnt == CW'(BLANK_CYCLES - 1)) begin
          w_state_nxt = ST_LATCH;
          w_cnt_clr   = 1'b1;
          w_addr_load = 1'b1;
        end
      end
      ST_LATCH: begin
        if (r_cnt == CW'(LATCH_CYCLES - 1)) begin
          w_state_nxt  = ST_DISPLAY;
          w_cnt_clr    = 1'b1;
          w_disp_start = 1'b1;
        end
      end
      ST_DISPLAY: begin
        if (w_disp_done) begin
          w_cnt_clr = 1'b1;
          if (r_row == ROW_AW'(LAST_ROW)) begin
            w_fd_nxt    = 1'b1;
            w_row_nxt   = '0;
            w_state_nxt = enable_in ? ST_FETCH : ST_IDLE;
          end else if (!enable_in) begin
            w_row_nxt   = '0;
            w_state_nxt = ST_IDLE;
          end else begin
            w_row_nxt   = r_row + ROW_AW'(1);
            w_state_nxt = ST_FETCH;
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      r_state      <= ST_IDLE;
      r_row        <= '0;
      r_cnt        <= '0;
      r_addr       <= '0;
      r_top        <= '0;
      r_bot        <= '0;
      r_frame_done <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_row        <= w_row_nxt;
      r_frame_done <= w_fd_nxt;
      if (w_cnt_clr)                 r_cnt <= '0;
      else if (r_cnt < CW'(CNT_MAX)) r_cnt <= r_cnt + CW'(1);
      if (w_addr_load) r_addr <= r_row;
      if (w_capture) begin
        r_top <= col_top_in;
        r_bot <= col_bot_in;
      end
    end
  end

  assign row_req_out     = (r_state == ST_FETCH);
  assign row_addr_out    = r_row;
  assign phy_enable_out  = (r_state == ST_SHIFT) && (r_cnt == '0);
  assign phy_col_top_out = r_top;
  assign phy_col_bot_out = r_bot;
  assign addr_out        = r_addr;
  assign le_out          = (r_state == ST_LATCH);
  assign oe_n_out        = w_oe_n || (r_state != ST_DISPLAY);
  assign frame_done_out  = r_frame_done;
  assign busy_out        = (r_state != ST_IDLE);

endmodule

// File: tb/tb_led_display_scan_ctrl.sv
// Randomized bench for led_display_scan_ctrl with a timeline reference model.
// Connects brightness_in when LED_SCAN_BRIGHTNESS_EN is defined.
module tb_led_display_scan_ctrl;

  localparam int NC    = 8;
  localparam int NR    = 32;
  localparam int ON_T  = 20;
  localparam int BL    = 4;
  localparam int LT    = 2;
  localparam int COLW  = 3 * NC;
  localparam int LASTR = NR / 2 - 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            reset_in     = 1'b1;
  logic            enable_in    = 1'b0;
  logic            row_valid_in = 1'b0;
  logic            phy_ready_in = 1'b0;
  logic [COLW-1:0] col_top_in   = '0;
  logic [COLW-1:0] col_bot_in   = '0;
`ifdef LED_SCAN_BRIGHTNESS_EN
  logic [7:0]      brightness_in = 8'd255;
`endif
  logic            row_req_out;
  logic [3:0]      row_addr_out;
  logic            phy_enable_out;
  logic [COLW-1:0] phy_col_top_out;
  logic [COLW-1:0] phy_col_bot_out;
  logic [3:0]      addr_out;
  logic            le_out;
  logic            oe_n_out;
  logic            frame_done_out;
  logic            busy_out;

  led_display_scan_ctrl #(
    .NUM_COLS(NC), .NUM_ROWS(NR), .ON_TIME_CYCLES(ON_T),
    .BLANK_CYCLES(BL), .LATCH_CYCLES(LT)
  ) dut (
    .clk_in(clk), .reset_in(reset_in), .enable_in(enable_in),
`ifdef LED_SCAN_BRIGHTNESS_EN
    .brightness_in(brightness_in),
`endif
    .row_req_out(row_req_out), .row_addr_out(row_addr_out),
    .row_valid_in(row_valid_in),
    .col_top_in(col_top_in), .col_bot_in(col_bot_in),
    .phy_enable_out(phy_enable_out), .phy_ready_in(phy_ready_in),
    .phy_col_top_out(phy_col_top_out), .phy_col_bot_out(phy_col_bot_out),
    .addr_out(addr_out), .le_out(le_out), .oe_n_out(oe_n_out),
    .frame_done_out(frame_done_out), .busy_out(busy_out)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int lat_valid = 3;
  int lat_ready = 10;
  bit junk = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h cycle=%0d", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [COLW-1:0] row_data(input int r, input bit bot);
    return bot ? COLW'(r + 256) : COLW'(r);
  endfunction

  function automatic int on_len(input int b);
`ifdef LED_SCAN_BRIGHTNESS_EN
    return (ON_T * b) >> 8;
`else
    return (b >= 0) ? ON_T : ON_T;
`endif
  endfunction

  // Frame store: answers a request lat_valid cycles after it starts.
  initial begin
    int age;
    age = 0;
    forever begin
      @(negedge clk);
      if (row_req_out && !row_valid_in && !reset_in) age++;
      else age = 0;
      @(posedge clk);
      #1;
      if (row_req_out && age >= lat_valid) begin
        row_valid_in = 1'b1;
        col_top_in   = row_data(int'(row_addr_out), 1'b0);
        col_bot_in   = row_data(int'(row_addr_out), 1'b1);
      end else begin
        row_valid_in = junk ? 1'($urandom_range(1)) : 1'b0;
        col_top_in   = COLW'($urandom);
        col_bot_in   = COLW'($urandom);
      end
    end
  end

  // PHY: ready lat_ready cycles after the shift enable.
  initial begin
    bit armed;
    int pa;
    armed = 0;
    pa = 0;
    forever begin
      @(negedge clk);
      if (phy_enable_out) begin
        armed = 1;
        pa = 0;
      end else if (armed) pa++;
      if (row_req_out || reset_in) armed = 0;
      @(posedge clk);
      #1;
      if (armed && pa + 1 >= lat_ready) phy_ready_in = 1'b1;
      else phy_ready_in = junk ? 1'($urandom_range(1)) : 1'b0;
    end
  end

  // Reference model: phase 0 idle, 1 fetching, 2 row timeline from f and s.
  int m_mode = 0, m_row = 0, m_f = 0, m_s = -1, m_on = ON_T;
  bit m_known = 0, m_fd = 0;
  logic [3:0]      m_addr = '0;
  logic [COLW-1:0] m_top = '0, m_bot = '0;

  int req_q[$];
  int reqc_q[$];
  int fd_cnt = 0, le_cnt = 0, oe_low = 0, pen_cnt = 0;
  int cap_cyc = 0, last_le_addr = -1;
  bit prev_req = 0, prev_le = 0;
  logic [COLW-1:0] panel [16];

  initial begin
    bit e_req, e_pen, e_le, e_oen;
    int d0;
    forever begin
      @(negedge clk);
      cyc++;
      if (m_known) begin
        d0 = m_s + BL + LT;
        e_req = (m_mode == 1);
        e_pen = (m_mode == 2) && (cyc == m_f + 1);
        e_le  = (m_mode == 2) && (m_s >= 0) &&
                (cyc > m_s + BL) && (cyc <= d0);
        e_oen = !((m_mode == 2) && (m_s >= 0) &&
                  (cyc > d0) && (cyc <= d0 + m_on));
        chk("row_req", 64'(row_req_out), 64'(e_req));
        if (e_req) chk("row_addr", 64'(row_addr_out), 64'(m_row));
        chk("phy_enable", 64'(phy_enable_out), 64'(e_pen));
        chk("le", 64'(le_out), 64'(e_le));
        chk("oe_n", 64'(oe_n_out), 64'(e_oen));
        chk("busy", 64'(busy_out), 64'(m_mode != 0));
        chk("frame_done", 64'(frame_done_out), 64'(m_fd));
        chk("addr", 64'(addr_out), 64'(m_addr));
        chk("col_top", 64'(phy_col_top_out), 64'(m_top));
        chk("col_bot", 64'(phy_col_bot_out), 64'(m_bot));
      end
      if (row_req_out && !prev_req) begin
        req_q.push_back(int'(row_addr_out));
        reqc_q.push_back(cyc);
      end
      if (row_req_out && row_valid_in) cap_cyc = cyc;
      if (frame_done_out) fd_cnt++;
      if (le_out && !prev_le) begin
        le_cnt++;
        last_le_addr = int'(addr_out);
        panel[addr_out] = phy_col_top_out;
      end
      if (!oe_n_out) oe_low++;
      if (phy_enable_out) pen_cnt++;
      prev_req = row_req_out;
      prev_le  = le_out;

      if (reset_in) begin
        m_known = 1; m_mode = 0; m_row = 0; m_fd = 0;
        m_addr = '0; m_top = '0; m_bot = '0;
      end else begin
        m_fd = 0;
        case (m_mode)
          0: if (enable_in) begin
            m_mode = 1;
            m_row = 0;
          end
          1: if (row_valid_in) begin
            m_top = col_top_in;
            m_bot = col_bot_in;
            m_f = cyc;
            m_s = -1;
            m_mode = 2;
          end
          default: begin
            if (m_s < 0) begin
              if (cyc >= m_f + 4 && phy_ready_in) m_s = cyc;
            end else begin
              if (cyc == m_s + BL) m_addr = 4'(m_row);
`ifdef LED_SCAN_BRIGHTNESS_EN
              if (cyc == m_s + BL + LT) m_on = on_len(int'(brightness_in));
`else
              if (cyc == m_s + BL + LT) m_on = on_len(255);
`endif
              if (cyc == m_s + BL + LT + ON_T) begin
                if (m_row == LASTR) begin
                  m_fd = 1;
                  m_row = 0;
                  m_mode = enable_in ? 1 : 0;
                end else if (!enable_in) begin
                  m_row = 0;
                  m_mode = 0;
                end else begin
                  m_row++;
                  m_mode = 1;
                end
              end
            end
          end
        endcase
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int n, qs, oe0;
    bit ok;
    int exp_on;
    exp_on = on_len(255);
    reset_in = 1'b1;
    repeat (3) step();
    reset_in = 1'b0;
    chk("rst_busy", 64'(busy_out), 64'd0);
    chk("rst_oe_n", 64'(oe_n_out), 64'd1);
    chk("rst_addr", 64'(addr_out), 64'd0);
    chk("rst_col", 64'(phy_col_top_out), 64'd0);
    step();

    // Full frame with fixed latencies: valid after 3, ready after 10.
    req_q.delete();
    reqc_q.delete();
    fd_cnt = 0; le_cnt = 0; oe_low = 0;
    enable_in = 1'b1;
    n = 0;
    while (fd_cnt == 0 && n < 2000) begin step(); n++; end
    chk("wait_frame_done", 64'(n < 2000), 64'd1);
    chk("req_count", 64'(req_q.size()), 64'd17);
    ok = 1;
    for (int i = 0; i < 16 && i < req_q.size(); i++)
      if (req_q[i] != i) ok = 0;
    chk("req_order", 64'(ok), 64'd1);
    if (reqc_q.size() >= 17) begin
      chk("row_period", 64'(reqc_q[1] - reqc_q[0]), 64'd41);
      chk("frame_period", 64'(reqc_q[16] - reqc_q[0]), 64'd656);
    end
    chk("frame_done_count", 64'(fd_cnt), 64'd1);
    chk("latch_count", 64'(le_cnt), 64'd16);
    chk("oe_low_frame", 64'(oe_low), 64'(16 * exp_on));
    ok = 1;
    for (int k = 0; k < 16; k++)
      if (panel[k] !== row_data(k, 1'b0)) ok = 0;
    chk("panel_rows", 64'(ok), 64'd1);

    // Drop enable during row 5 shift.
    n = 0;
    while (!(phy_enable_out && row_addr_out == 4'd5) && n < 1000) begin
      step(); n++;
    end
    chk("wait_row5_shift", 64'(n < 1000), 64'd1);
    enable_in = 1'b0;
    qs = req_q.size();
    oe_low = 0;
    n = 0;
    while (busy_out && n < 200) begin step(); n++; end
    chk("wait_idle", 64'(n < 200), 64'd1);
    chk("no_row6_fetch", 64'(req_q.size()), 64'(qs));
    chk("row5_latched", 64'(last_le_addr), 64'd5);
    chk("row5_display", 64'(oe_low), 64'(exp_on));
    chk("idle_oe_n", 64'(oe_n_out), 64'd1);
    chk("idle_busy", 64'(busy_out), 64'd0);

    // Reset during row 7 display.
    enable_in = 1'b1;
    n = 0;
    while (!(!oe_n_out && addr_out == 4'd7) && n < 1000) begin
      step(); n++;
    end
    chk("wait_row7_display", 64'(n < 1000), 64'd1);
    reset_in = 1'b1;
    step();
    reset_in = 1'b0;
    enable_in = 1'b0;
    chk("mid_rst_busy", 64'(busy_out), 64'd0);
    chk("mid_rst_oe_n", 64'(oe_n_out), 64'd1);
    chk("mid_rst_addr", 64'(addr_out), 64'd0);
    chk("mid_rst_le", 64'(le_out), 64'd0);
    chk("mid_rst_req", 64'(row_req_out), 64'd0);
    chk("mid_rst_col", 64'(phy_col_bot_out), 64'd0);
    repeat (5) step();

    // Restart with a 500-cycle frame store stall on the first row.
    lat_valid = 500;
    qs = req_q.size();
    enable_in = 1'b1;
    n = 0;
    while (req_q.size() == qs && n < 50) begin step(); n++; end
    chk("restart_req", 64'(req_q.size() > qs), 64'd1);
    if (req_q.size() > qs) chk("restart_row", 64'(req_q[$]), 64'd0);
    pen_cnt = 0;
    oe_low = 0;
    n = 0;
    while (row_req_out && n < 600) begin step(); n++; end
    chk("wait_stall_end", 64'(n < 600), 64'd1);
    chk("stall_len", 64'(cap_cyc - reqc_q[$] + 1), 64'd501);
    chk("stall_phy_en", 64'(pen_cnt), 64'd0);
    chk("stall_oe", 64'(oe_low), 64'd0);
    lat_valid = 3;
    oe0 = fd_cnt;
    repeat (100) step();
    chk("after_stall_busy", 64'(busy_out), 64'd1);

    // Randomized traffic against the model.
    junk = 1;
    for (int it = 0; it < 40; it++) begin
      lat_valid = $urandom_range(0, 6);
      lat_ready = $urandom_range(0, 14);
`ifdef LED_SCAN_BRIGHTNESS_EN
      brightness_in = 8'($urandom);
`endif
      if ($urandom_range(5) == 0) enable_in = ~enable_in;
      if ($urandom_range(9) == 0) begin
        reset_in = 1'b1;
        step();
        reset_in = 1'b0;
      end
      repeat ($urandom_range(20, 300)) step();
    end
    chk("random_frames_seen", 64'(fd_cnt >= oe0), 64'd1);

    enable_in = 1'b0;
    n = 0;
    while (busy_out && n < 2000) begin step(); n++; end
    chk("final_idle", 64'(busy_out), 64'd0);
    chk("final_oe_n", 64'(oe_n_out), 64'd1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
